cpu_control: RTL and testbench

- Instruction sequencer for the PIC10-compatible CPU.
- Fetches 12-bit instructions from program ROM and runs each one through a 4-phase cycle: FETCH, DECODE, EXECUTE, WRITE.
- Drives the ALU opcode, owns PC, the 2-level call stack, STATUS C/DC/Z and the skip logic, and issues W and register-file write enables.
- Sits between program ROM, cpu_alu, the W register and the register file.

---
 rtl/cpu_control_if.sv | 30 +++
 rtl/cpu_control.sv | 110 +++++++++++
 tb/tb_cpu_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_control_if.sv
// cpu_control_if: ROM, ALU and register-file signals between the sequencer and the datapath.
interface cpu_control_if #(parameter int PC_WIDTH = 9);
  logic [PC_WIDTH-1:0] rom_addr_out;
  logic [11:0]         rom_data_in;
  logic [11:0]         alu_op_out;
  logic [7:0]          alu_result_in;
  logic [2:0]          alu_status_in;
  logic                status_c_load_in;
  logic                status_dc_load_in;
  logic                status_z_load_in;
  logic                status_carry_out;
  logic [2:0]          status_out;
  logic [4:0]          file_addr_out;
  logic                file_we_out;
  logic                w_we_out;
  logic [1:0]          phase_out;
  logic                halted_out;
  modport master (
    output rom_addr_out, alu_op_out, status_carry_out, status_out, file_addr_out,
           file_we_out, w_we_out, phase_out, halted_out,
    input  rom_data_in, alu_result_in, alu_status_in, status_c_load_in,
           status_dc_load_in, status_z_load_in
  );
  modport slave (
    input  rom_addr_out, alu_op_out, status_carry_out, status_out, file_addr_out,
           file_we_out, w_we_out, phase_out, halted_out,
    output rom_data_in, alu_result_in, alu_status_in, status_c_load_in,
           status_dc_load_in, status_z_load_in
  );
endinterface

// File: rtl/cpu_control.sv
// cpu_control: 4-phase PIC10 instruction sequencer owning PC, call stack, STATUS and skip logic.
module cpu_control #(
  parameter int                  PC_WIDTH     = 9,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(9'h1FF)
) (
  input logic           clk,
  input logic           reset_n,
  cpu_control_if.master bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITE} phase_t;
  phase_t              phase_q, phase_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, stk0_q, stk0_d, stk1_q, stk1_d, tgt_q, tgt_d;
  logic [11:0]         ir_q, ir_d;
  logic [2:0]          status_q, status_d;
  logic                skip_q, skip_d, jmp_q, jmp_d, halted_q, halted_d;
  logic byte_op, misc, d, bit_set, retlw, call, goto_op, lit, fsz, btfsc, btfss;
  logic wr, z_in, skip, w_we, file_we, pcl_wr, stat_wr, jump, sleep_op;
  logic [2:0]          ld;
  logic [PC_WIDTH-1:0] tgt;
  always_comb begin
    byte_op  = ir_q[11:10] == 2'b00;
    misc     = byte_op && ir_q[9:6] == 4'h0;
    d        = ir_q[5];
    bit_set  = ir_q[11:9] == 3'b010;
    btfsc    = ir_q[11:8] == 4'h6;
    btfss    = ir_q[11:8] == 4'h7;
    retlw    = ir_q[11:8] == 4'h8;
    call     = ir_q[11:8] == 4'h9;
    goto_op  = ir_q[11:9] == 3'b101;
    lit      = ir_q[11:10] == 2'b11;
    fsz      = byte_op && (ir_q[9:6] == 4'hB || ir_q[9:6] == 4'hF);
    sleep_op = ir_q == 12'h003;
    wr       = phase_q == WRITE;
    z_in     = bus.alu_status_in[2];
    w_we     = wr && ((byte_op && !misc && !d) || retlw || lit);
    file_we  = wr && ((byte_op && d) || bit_set);
    pcl_wr   = file_we && ir_q[4:0] == 5'h02;
    stat_wr  = file_we && ir_q[4:0] == 5'h03;
    skip     = ((fsz || btfsc) && z_in) || (btfss && !z_in);
    jump     = goto_op || call || retlw || pcl_wr;
    ld       = {bus.status_z_load_in, bus.status_dc_load_in, bus.status_c_load_in};
    tgt      = goto_op ? PC_WIDTH'(ir_q[8:0]) : call ? PC_WIDTH'(ir_q[7:0]) :
               retlw ? stk0_q : PC_WIDTH'(bus.alu_result_in);
  end
  // A branch target waits one cycle so the forced NOP fetches from the old PC+1.
  always_comb begin
    phase_d  = phase_q;
    pc_d     = pc_q;
    stk0_d   = stk0_q;
    stk1_d   = stk1_q;
    tgt_d    = tgt_q;
    ir_d     = ir_q;
    status_d = status_q;
    skip_d   = skip_q;
    jmp_d    = jmp_q;
    halted_d = halted_q;
    if (!halted_q) begin
      phase_d = phase_t'(phase_q + 2'd1);
      if (phase_q == FETCH) begin
        ir_d   = skip_q ? 12'h000 : bus.rom_data_in;
        pc_d   = jmp_q ? tgt_q : pc_q + PC_WIDTH'(1);
        skip_d = 1'b0;
        jmp_d  = 1'b0;
      end
      if (wr) begin
        status_d = (ld & bus.alu_status_in) | (~ld & (stat_wr ? bus.alu_result_in[2:0] : status_q));
        skip_d   = jump || skip;
        jmp_d    = jump;
        tgt_d    = tgt;
        stk0_d   = call ? pc_q : retlw ? stk1_q : stk0_q;
        stk1_d   = call ? stk0_q : stk1_q;
        halted_d = sleep_op;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= FETCH;
      pc_q     <= RESET_VECTOR;
      stk0_q   <= '0;
      stk1_q   <= '0;
      tgt_q    <= '0;
      ir_q     <= 12'h000;
      status_q <= 3'b000;
      skip_q   <= 1'b0;
      jmp_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      stk0_q   <= stk0_d;
      stk1_q   <= stk1_d;
      tgt_q    <= tgt_d;
      ir_q     <= ir_d;
      status_q <= status_d;
      skip_q   <= skip_d;
      jmp_q    <= jmp_d;
      halted_q <= halted_d;
    end
  end
  assign bus.rom_addr_out     = pc_q;
  assign bus.alu_op_out       = ir_q;
  assign bus.status_carry_out = status_q[0];
  assign bus.status_out       = status_q;
  assign bus.file_addr_out    = ir_q[4:0];
  assign bus.file_we_out      = file_we;
  assign bus.w_we_out         = w_we;
  assign bus.phase_out        = phase_q;
  assign bus.halted_out       = halted_q;
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: instruction-level reference model feeding a scoreboard checked at each WRITE phase.
module tb_cpu_control;
  logic clk, reset_n;
  logic [11:0] rom [512];
  cpu_control_if #(.PC_WIDTH(9)) bus ();
  cpu_control #(.PC_WIDTH(9), .RESET_VECTOR(9'h1FF)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  assign bus.rom_data_in = rom[bus.rom_addr_out];
  always #5 clk = ~clk;

  typedef struct {int fetch; int pc; int ir; int w; int f; int st;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int total, bad, fetch_seen;
  int m_pc, m_tgt, m_st, m_stk[2];
  bit m_skip, m_jmp, m_halt;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 'h1FF; m_tgt = 0; m_st = 0; m_stk[0] = 0; m_stk[1] = 0;
    m_skip = 0; m_jmp = 0; m_halt = 0;
  endtask

  // One whole instruction cycle at instruction level; also drives the ALU side for it.
  task automatic step(input int res, input int ast, input int ld);
    exp_t e;
    int ins, fa, tgt, keep;
    bit d, z, skp, jump;
    bus.alu_result_in = res[7:0];
    bus.alu_status_in = ast[2:0];
    {bus.status_z_load_in, bus.status_dc_load_in, bus.status_c_load_in} = ld[2:0];
    e.fetch = m_pc;
    e.st = m_st;
    ins = m_skip ? 0 : int'(rom[m_pc]);
    m_pc = m_jmp ? m_tgt : (m_pc + 1) % 512;
    e.pc = m_pc; e.ir = ins; e.w = 0; e.f = 0;
    fa = ins % 32; d = ((ins >> 5) & 1) != 0; z = (ast & 4) != 0;
    skp = 0; jump = 0; tgt = 0;
    if (ins < 'h40) e.f = (ins >= 'h20);
    else if (ins < 'h400) begin
      e.w = !d; e.f = d;
      if ((ins >> 6) == 'h0B || (ins >> 6) == 'h0F) skp = z;
    end
    else if (ins < 'h600) e.f = 1;
    else if (ins < 'h700) skp = z;
    else if (ins < 'h800) skp = !z;
    else if (ins < 'h900) begin e.w = 1; jump = 1; tgt = m_stk[0]; m_stk[0] = m_stk[1]; end
    else if (ins < 'hA00) begin jump = 1; tgt = ins % 256; m_stk[1] = m_stk[0]; m_stk[0] = m_pc; end
    else if (ins < 'hC00) begin jump = 1; tgt = ins % 512; end
    else e.w = 1;
    if (e.f != 0 && fa == 2) begin jump = 1; tgt = res % 256; end
    keep = (e.f != 0 && fa == 3) ? res % 8 : m_st;
    m_st = ((ast & ld) | (keep & ~ld)) & 7;
    if (ins == 3) m_halt = 1;
    m_skip = jump || skp; m_jmp = jump; m_tgt = tgt;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (reset_n) begin
    if (bus.phase_out == 2'd0) fetch_seen = bus.rom_addr_out;
    if (bus.phase_out != 2'd3) chk("idle_strobes", {bus.w_we_out, bus.file_we_out}, 0);
    else if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got write phase at %0h, want none", bus.rom_addr_out);
    end else begin
      mon_e = sbq.pop_front();
      chk("fetch_addr", fetch_seen, mon_e.fetch);
      chk("pc", bus.rom_addr_out, mon_e.pc);
      chk("ir", bus.alu_op_out, mon_e.ir);
      chk("w_we", bus.w_we_out, mon_e.w);
      chk("file_we", bus.file_we_out, mon_e.f);
      chk("file_addr", bus.file_addr_out, mon_e.ir % 32);
      chk("status", bus.status_out, mon_e.st);
      chk("carry", bus.status_carry_out, mon_e.st % 2);
    end
  end

  initial begin
    int r, a, l, n;
    clk = 0; reset_n = 0; total = 0; bad = 0; fetch_seen = 0;
    bus.alu_result_in = 0; bus.alu_status_in = 0;
    {bus.status_z_load_in, bus.status_dc_load_in, bus.status_c_load_in} = 3'b000;
    for (int i = 0; i < 512; i++) begin
      rom[i] = 12'($urandom_range(0, 4095));
      if (rom[i] == 12'h003) rom[i] = 12'h000;
    end
    rom['h1FF] = 12'hC2A; rom['h000] = 12'hA25; rom['h025] = 12'hA05;
    rom['h005] = 12'h910; rom['h010] = 12'h920; rom['h020] = 12'h855;
    rom['h011] = 12'h800; rom['h006] = 12'h2E4; rom['h008] = 12'h2E4;
    rom['h009] = 12'hC33; rom['h00A] = 12'h1E3; rom['h00B] = 12'h6A5;
    #12;
    chk("rst_pc", bus.rom_addr_out, 'h1FF);
    chk("rst_phase", bus.phase_out, 0);
    chk("rst_ir", bus.alu_op_out, 0);
    chk("rst_status", bus.status_out, 0);
    chk("rst_halted", bus.halted_out, 0);
    chk("rst_strobes", {bus.w_we_out, bus.file_we_out}, 0);
    m_reset();
    @(negedge clk) reset_n = 1;
    for (int k = 0; k < 20; k++) begin
      r = k; a = 0; l = 0;
      if (k == 13 || k == 18) a = 4;
      if (k == 15) r = 'h10;
      if (k == 17) begin r = 'hFC; a = 3; l = 7; end
      step(r, a, l);
      cyc();
    end
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 255); a = $urandom_range(0, 7); l = $urandom_range(0, 7);
      if (m_skip || rom[m_pc] == 12'h000) l = 0;
      step(r, a, l);
      cyc();
    end
    chk("sb_drain", sbq.size(), 0);
    reset_n = 0;
    rom['h1FF] = 12'hA03; rom['h003] = 12'h003;
    m_reset();
    #3;
    @(negedge clk) reset_n = 1;
    n = 0;
    while (!m_halt && n < 10) begin
      step($urandom_range(0, 255), $urandom_range(0, 7), 0);
      cyc();
      n++;
    end
    chk("sleep_reached", m_halt, 1);
    chk("sb_drain_sleep", sbq.size(), 0);
    repeat (20) begin
      @(negedge clk);
      chk("halt_addr", bus.rom_addr_out, m_pc);
      chk("halted", bus.halted_out, 1);
    end
    #3 reset_n = 0;
    #1;
    chk("wake_pc", bus.rom_addr_out, 'h1FF);
    chk("wake_phase", bus.phase_out, 0);
    chk("wake_halted", bus.halted_out, 0);
    rom['h1FF] = 12'hC2A;
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1 chk("decode_phase", bus.phase_out, 1);
    #2 reset_n = 0;
    #1;
    chk("abort_pc", bus.rom_addr_out, 'h1FF);
    chk("abort_phase", bus.phase_out, 0);
    chk("abort_ir", bus.alu_op_out, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_write", {bus.w_we_out, bus.file_we_out}, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
